jump_target_gen: RTL
====================

# jump_target_gen

- Parametrised, pipelined jump/branch target generator for the MIPS BTB datapath.
- Supersedes the fixed 26→32 shift-left-2 jump helper.
- Accepts a PC, immediate/register operand and mode under a valid/ready handshake, and emits the registered target address plus a misalignment flag.
- Sits between decode and the BTB update/fetch-redirect logic.

## Interface
Parameters:
- AW, 32: address width.
- IW, 26: jump index width; must satisfy IW + SH ≤ AW.
- OW, 16: branch offset width (sign-extended).
- SH, 2: left-shift amount (log2 instruction bytes).

Ports:
- Clk  in  1  rising-edge clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- in_mode  in  2  operation: 0 = J (pseudo-direct), 1 = BR (PC-relative), 2 = JR (register), 3 = reserved.
- in_pc  in  AW  PC of the instruction.
- in_index  in  IW  jump index (J).
- in_offset  in  OW  signed branch offset (BR).
- in_reg  in  AW  register operand (JR).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_target  out  AW  computed target.
- out_misalign  out  1  target low SH bits non-zero (JR only).
- out_bad_mode  out  1  request used mode 3.

## Operation
- pc4 = in_pc + (1<<SH), modulo 2^AW.
- J mode:
  - target = {upper AW−IW−SH bits, in_index, SH zeros}.
  - Upper bits are selected by the macro under Configuration.
  - out_misalign = 0.
- BR mode:
  - target = pc4 + (sign_extend(in_offset) << SH), truncated to AW; wrap-around is silent.
  - out_misalign = 0.
- JR mode:
  - target = in_reg, passed unmodified.
  - out_misalign = |in_reg[SH-1:0].
- Mode 3:
  - target = 0, out_bad_mode = 1, out_misalign = 0.
  - The request is still handed off normally; it is never dropped.
- Compute is combinational from the inputs. Results are held in a 2-entry buffer: a main output register plus one skid register.
- Buffer states:
  - EMPTY: out_valid = 0, in_ready = 1.
  - ONE: out_valid = 1, in_ready = 1.
  - FULL: out_valid = 1, in_ready = 0.
- Transitions (accept = in_valid & in_ready; drain = out_valid & out_ready):
  - EMPTY, accept → ONE.
  - ONE, accept & !drain → FULL; the new result goes to skid.
  - ONE, accept & drain → ONE; the output register is reloaded.
  - ONE, !accept & drain → EMPTY.
  - FULL, drain → ONE; skid moves to output. No accept is possible.
- Ordering is strictly FIFO.
- in_ready depends only on state, never combinationally on out_ready.

## Timing
- Latency: a request accepted at edge N appears on out_* after edge N, i.e. valid in cycle N+1.
- Throughput: 1 result/cycle while out_ready is held high.
- out_* registers stay stable while out_valid & !out_ready.
- Reset:
  - State goes to EMPTY.
  - out_valid = 0, out_target = 0, out_misalign = 0, out_bad_mode = 0.
  - in_ready = 0 during the Reset cycle and 1 on the first cycle after.
- Reset mid-operation discards both buffered results; there is no partial drain.
- Request payload is sampled only on accept. Payload changes without in_valid have no effect.

## Configuration
- JTG_PCHI_EN defined: J-mode upper bits = pc4[AW-1:IW+SH]. This is the architecturally correct MIPS pseudo-direct target.
- JTG_PCHI_EN undefined: J-mode upper bits = 0. This keeps compatibility with the legacy zero-filled jump target.
- No other behaviour differs between the two builds.

## Structure
- Shared package jtg_pkg holds:
  - mode encodings MODE_J, MODE_BR, MODE_JR, MODE_RSVD;
  - the buffer state encodings.
- Sub-module jtg_skid_buf: the 2-entry valid/ready buffer, parametrised on payload width (AW+2).
- The top level holds the target arithmetic and instantiates jtg_skid_buf once.

## Test plan
- J, JTG_PCHI_EN defined: pc=0x9000_0000, index=0x000_0040, out_ready=1 → target 0x9000_0100 one cycle later. Same request without the macro → 0x0000_0100.
- BR negative wrap: pc=0x0000_0000, offset=0xFFFF → target 0x0000_0000 (pc4 − 4). BR pc=0xFFFF_FFF8, offset=0x0001 → target 0x0000_0000.
- JR: reg=0x0040_0002 → target 0x0040_0002, out_misalign=1. Mode 3 → target 0, out_bad_mode=1.
- Backpressure: hold out_ready=0 and issue 3 back-to-back requests. Required: in_ready drops after 2 are accepted; then out_ready=1 drains them in order over 2 cycles with no loss or duplication.
- Streaming: out_ready=1 and in_valid=1 for 8 cycles → 8 consecutive out_valid cycles with in_ready constantly 1.
- Reset while FULL → next cycle out_valid=0, all outputs 0; the first post-reset request emerges alone.

Source files
------------

// File: rtl/jtg_pkg.sv
// Shared definitions for the jump/branch target generator:
// operation mode encodings and the result-buffer state encoding.
package jtg_pkg;

  // Request operation modes.
  localparam logic [1:0] MODE_J    = 2'd0;  // pseudo-direct jump
  localparam logic [1:0] MODE_BR   = 2'd1;  // PC-relative branch
  localparam logic [1:0] MODE_JR   = 2'd2;  // register jump
  localparam logic [1:0] MODE_RSVD = 2'd3;  // reserved, flagged as bad mode

  // Occupancy of the 2-entry result buffer.
  typedef enum logic [1:0] {
    BufEmpty = 2'd0,
    BufOne   = 2'd1,
    BufFull  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/jtg_skid_buf.sv
// Two-entry valid/ready result buffer: a main output register plus one skid register.
// Ready depends only on occupancy (and reset), never on the downstream ready, so the
// upstream handshake is fully registered. Ordering is strictly FIFO.
module jtg_skid_buf
  import jtg_pkg::*;
#(
  parameter int unsigned W = 34
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  buf_state_e r_state;
  buf_state_e w_state_next;
  logic [W-1:0] r_out;
  logic [W-1:0] r_skid;

  logic w_accept;
  logic w_drain;
  logic w_load_out;
  logic w_load_skid;
  logic w_skid_to_out;

  // Handshake outputs derived from occupancy only; reset blocks acceptance.
  always_comb begin
    o_ready  = (r_state != BufFull) && !i_rst;
    o_valid  = (r_state != BufEmpty);
    o_data   = r_out;
    w_accept = i_valid && o_ready;
    w_drain  = o_valid && i_ready;
  end

  // Next-state and register-load decisions for the buffer.
  always_comb begin
    w_state_next  = r_state;
    w_load_out    = 1'b0;
    w_load_skid   = 1'b0;
    w_skid_to_out = 1'b0;
    case (r_state)
      BufEmpty: begin
        if (w_accept) begin
          w_state_next = BufOne;
          w_load_out   = 1'b1;
        end
      end
      BufOne: begin
        if (w_accept && !w_drain) begin
          w_state_next = BufFull;
          w_load_skid  = 1'b1;
        end else if (w_accept && w_drain) begin
          w_load_out = 1'b1;
        end else if (w_drain) begin
          w_state_next = BufEmpty;
        end
      end
      BufFull: begin
        // No accept possible here; draining promotes the skid entry.
        if (w_drain) begin
          w_state_next  = BufOne;
          w_skid_to_out = 1'b1;
        end
      end
      default: w_state_next = BufEmpty;
    endcase
  end

  // State and payload registers; reset discards both entries.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= BufEmpty;
      r_out   <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load_out) begin
        r_out <= i_data;
      end else if (w_skid_to_out) begin
        r_out <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= i_data;
      end
    end
  end

endmodule

// File: rtl/jump_target_gen.sv
// Pipelined jump/branch target generator for the BTB datapath.
// Computes J / BR / JR targets combinationally and registers them through a
// 2-entry skid buffer (latency 1, throughput 1/cycle).
// Build option: define JTG_PCHI_EN to fill J-mode upper bits from pc4 (MIPS
// pseudo-direct); otherwise they are zero (legacy zero-filled target).
module jump_target_gen
  import jtg_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned IW = 26,
  parameter int unsigned OW = 16,
  parameter int unsigned SH = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_mode,
  input  logic [AW-1:0] in_pc,
  input  logic [IW-1:0] in_index,
  input  logic [OW-1:0] in_offset,
  input  logic [AW-1:0] in_reg,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_target,
  output logic          out_misalign,
  output logic          out_bad_mode
);

  localparam int unsigned PW = AW + 2;

  logic [AW-1:0] w_pc4;
  logic [AW-1:0] w_j_low;
  logic [AW-1:0] w_j_hi;
  logic [AW-1:0] w_off_ext;
  logic [AW-1:0] w_target;
  logic          w_misalign;
  logic          w_bad_mode;
  logic [PW-1:0] w_payload;
  logic [PW-1:0] w_out_payload;

  // Shared address terms: pc4, shifted jump index, sign-extended branch offset.
  always_comb begin
    w_pc4     = in_pc + (AW'(1) << SH);
    w_j_low   = AW'(in_index) << SH;
    w_off_ext = AW'($signed(in_offset));
`ifdef JTG_PCHI_EN
    // Keep only pc4 bits above the index field; mask is empty when IW+SH == AW.
    w_j_hi    = w_pc4 & ~((AW'(1) << (IW + SH)) - AW'(1));
`else
    w_j_hi    = '0;
`endif
  end

  // Per-mode target selection and flags.
  always_comb begin
    w_target   = '0;
    w_misalign = 1'b0;
    w_bad_mode = 1'b0;
    case (in_mode)
      MODE_J:  w_target = w_j_hi | w_j_low;
      MODE_BR: w_target = w_pc4 + (w_off_ext << SH);
      MODE_JR: begin
        w_target   = in_reg;
        w_misalign = |in_reg[SH-1:0];
      end
      default: w_bad_mode = 1'b1;
    endcase
    w_payload = {w_target, w_misalign, w_bad_mode};
  end

  jtg_skid_buf #(
    .W (PW)
  ) u_skid_buf (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_payload),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_out_payload)
  );

  // Unpack the registered payload onto the result ports.
  always_comb begin
    out_target   = w_out_payload[PW-1:2];
    out_misalign = w_out_payload[1];
    out_bad_mode = w_out_payload[0];
  end

endmodule
